// File: rtl/image_in_burst_ctrl.sv
// Camera-input FIFO read scheduler: issues DDR write bursts, paces FIFO reads, rotates frame buffers.
// Optional statistics outputs (burst count, peak water level) are enabled with IMAGE_IN_BURST_STAT_EN.
module image_in_burst_ctrl #(
  parameter int          BURST_LEN   = 16,
  parameter int          LEN_WIDTH   = 8,
  parameter int          LVL_WIDTH   = 10,
  parameter int          ADDR_WIDTH  = 28,
  parameter int          FRAME_WORDS = 230400,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] BUF_STRIDE  = 32'h0020_0000,
  parameter int          BUF_NUM     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_frame_start,
  input  logic [LVL_WIDTH-1:0]  i_fifo_rd_water_level,
  input  logic                  i_fifo_rd_empty,
  output logic                  o_fifo_rd_en,
  output logic                  o_wr_req,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [LEN_WIDTH-1:0]  o_wr_len,
  input  logic                  i_wr_ack,
  input  logic                  i_wr_data_req,
  output logic                  o_wr_data_valid,
  output logic                  o_frame_done,
  output logic [1:0]            o_done_buf,
  output logic                  o_frame_err
`ifdef IMAGE_IN_BURST_STAT_EN
  ,
  output logic [15:0]           o_burst_cnt,
  output logic [LVL_WIDTH-1:0]  o_max_lvl
`endif
);

  localparam int WC_W = $clog2(FRAME_WORDS + 1);
  localparam int BL_W = $clog2(BURST_LEN + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REQ, S_XFER, S_DONE} state_t;

  state_t                r_state, w_state_next;
  logic [1:0]            r_buf_idx, w_next_idx, w_base_idx;
  logic [WC_W-1:0]       r_word_cnt;
  logic [ADDR_WIDTH-1:0] r_cur_addr, w_base;
  logic [BL_W-1:0]       r_beats, r_blen, w_blen;
  logic [31:0]           w_rem;
  logic                  r_pending, w_issue, w_rd_en, w_burst_end, w_frame_full, w_restart;
  logic                  r_wr_req, r_rd_valid, r_frame_done, r_frame_err;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [LEN_WIDTH-1:0]  r_wr_len;
  logic [1:0]            r_done_buf;
  logic                  w_unused;

  // The FIFO can never be empty during a read because a burst only starts once the level covers it.
  assign w_unused = &{1'b0, i_fifo_rd_empty};

  // In DONE the next frame (if any) starts at the following buffer, elsewhere at the current one.
  assign w_next_idx   = (r_buf_idx == 2'(BUF_NUM - 1)) ? 2'd0 : r_buf_idx + 2'd1;
  assign w_base_idx   = (r_state == S_DONE) ? w_next_idx : r_buf_idx;
  assign w_base       = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(BUF_STRIDE) * ADDR_WIDTH'(w_base_idx);

  assign w_rem        = 32'(FRAME_WORDS) - 32'(r_word_cnt);
  assign w_blen       = (w_rem < 32'(BURST_LEN)) ? BL_W'(w_rem) : BL_W'(BURST_LEN);
  assign w_issue      = 32'(i_fifo_rd_water_level) >= 32'(w_blen);
  assign w_rd_en      = (r_state == S_XFER) && i_wr_data_req && (r_beats != '0);
  assign w_burst_end  = w_rd_en && (r_beats == BL_W'(1));
  assign w_frame_full = (r_word_cnt + WC_W'(1)) == WC_W'(FRAME_WORDS);
  assign w_restart    = r_pending || i_frame_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_frame_start) w_state_next = S_WAIT;
      S_WAIT:  if (!i_frame_start && w_issue) w_state_next = S_REQ;
      S_REQ:   if (i_wr_ack) w_state_next = S_XFER;
      S_XFER:  if (w_burst_end) w_state_next = w_frame_full ? S_DONE : S_WAIT;
      S_DONE:  w_state_next = w_restart ? S_WAIT : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // A frame_start seen during a burst is held until the burst drains, then abandons the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_idx    <= 2'd0;
      r_word_cnt   <= '0;
      r_cur_addr   <= ADDR_WIDTH'(BASE_ADDR);
      r_beats      <= '0;
      r_blen       <= '0;
      r_pending    <= 1'b0;
      r_wr_req     <= 1'b0;
      r_wr_addr    <= ADDR_WIDTH'(BASE_ADDR);
      r_wr_len     <= '0;
      r_rd_valid   <= 1'b0;
      r_frame_done <= 1'b0;
      r_done_buf   <= 2'(BUF_NUM - 1);
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_rd_valid   <= w_rd_en;
      case (r_state)
        S_IDLE: begin
          if (i_frame_start) begin
            r_word_cnt <= '0;
            r_cur_addr <= w_base;
          end
        end
        S_WAIT: begin
          if (i_frame_start) begin
            r_frame_err <= 1'b1;
            r_word_cnt  <= '0;
            r_cur_addr  <= w_base;
          end else if (w_issue) begin
            r_wr_req  <= 1'b1;
            r_wr_addr <= r_cur_addr;
            r_wr_len  <= LEN_WIDTH'(w_blen - BL_W'(1));
            r_blen    <= w_blen;
          end
        end
        S_REQ: begin
          if (i_frame_start) r_pending <= 1'b1;
          if (i_wr_ack) begin
            r_wr_req <= 1'b0;
            r_beats  <= r_blen;
          end
        end
        S_XFER: begin
          if (i_frame_start) r_pending <= 1'b1;
          if (w_rd_en) begin
            r_beats    <= r_beats - BL_W'(1);
            r_word_cnt <= r_word_cnt + WC_W'(1);
          end
          if (w_burst_end) begin
            r_cur_addr <= r_cur_addr + (ADDR_WIDTH'(r_blen) << 3);
            if (!w_frame_full && w_restart) begin
              r_frame_err <= 1'b1;
              r_pending   <= 1'b0;
              r_word_cnt  <= '0;
              r_cur_addr  <= w_base;
            end
          end
        end
        S_DONE: begin
          r_frame_done <= 1'b1;
          r_done_buf   <= r_buf_idx;
          r_buf_idx    <= w_next_idx;
          if (w_restart) begin
            r_pending  <= 1'b0;
            r_word_cnt <= '0;
            r_cur_addr <= w_base;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_fifo_rd_en    = w_rd_en;
  assign o_wr_req        = r_wr_req;
  assign o_wr_addr       = r_wr_addr;
  assign o_wr_len        = r_wr_len;
  assign o_wr_data_valid = r_rd_valid;
  assign o_frame_done    = r_frame_done;
  assign o_done_buf      = r_done_buf;
  assign o_frame_err     = r_frame_err;

`ifdef IMAGE_IN_BURST_STAT_EN
  logic [15:0]          r_burst_cnt;
  logic [LVL_WIDTH-1:0] r_max_lvl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_burst_cnt <= '0;
      r_max_lvl   <= '0;
    end else begin
      if (i_wr_ack) r_burst_cnt <= r_burst_cnt + 16'd1;
      if (i_fifo_rd_water_level > r_max_lvl) r_max_lvl <= i_fifo_rd_water_level;
    end
  end

  assign o_burst_cnt = r_burst_cnt;
  assign o_max_lvl   = r_max_lvl;
`endif

endmodule

// File: tb/tb_image_in_burst_ctrl.sv
// Scoreboard bench for image_in_burst_ctrl: expected bursts/frame completions are queued when
// a frame is started and popped when the DUT requests a burst or reports a finished frame.
`timescale 1ns/1ps
module tb_image_in_burst_ctrl;

  localparam int FW  = 40;
  localparam int BL  = 16;
  localparam int LW  = 8;
  localparam int LVW = 10;
  localparam int AW  = 28;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } burst_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           frameStart = 1'b0;
  logic [LVW-1:0] level = '0;
  logic           fifoEmpty = 1'b1;
  logic           wrAck = 1'b0;
  logic           dataReq = 1'b0;
  logic           fifoRdEn, wrReq, dataValid, frameDone, frameErr;
  logic [AW-1:0]  wrAddr;
  logic [LW-1:0]  wrLen;
  logic [1:0]     doneBuf;
`ifdef IMAGE_IN_BURST_STAT_EN
  logic [15:0]    burstCnt;
  logic [LVW-1:0] maxLvl;
`endif

  burst_t expBurstQ[$];
  int     expDoneQ[$];
  int     checks = 0, errors = 0;
  int     ackDelay = 0, reqMode = 2;
  int     ackCount = 0, doneCount = 0;
  int     readsSeen = 0, beatsExp = 0, rdTotal = 0;
  bit     burstOpen = 1'b0;
  logic   prevRdEn = 1'b0;
  int     nextBuf = 0;
  int     rotExp[4] = '{0, 1, 2, 0};

  image_in_burst_ctrl #(
    .BURST_LEN(BL), .LEN_WIDTH(LW), .LVL_WIDTH(LVW), .ADDR_WIDTH(AW),
    .FRAME_WORDS(FW), .BASE_ADDR(32'd0), .BUF_STRIDE(32'd4096), .BUF_NUM(3)
  ) dut (
    .clk(clk), .rst(rst), .i_frame_start(frameStart),
    .i_fifo_rd_water_level(level), .i_fifo_rd_empty(fifoEmpty),
    .o_fifo_rd_en(fifoRdEn), .o_wr_req(wrReq), .o_wr_addr(wrAddr), .o_wr_len(wrLen),
    .i_wr_ack(wrAck), .i_wr_data_req(dataReq), .o_wr_data_valid(dataValid),
    .o_frame_done(frameDone), .o_done_buf(doneBuf), .o_frame_err(frameErr)
`ifdef IMAGE_IN_BURST_STAT_EN
    , .o_burst_cnt(burstCnt), .o_max_lvl(maxLvl)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic pushFrame(input int bufIdx, input int maxBursts, input bit withDone);
    int w = 0;
    int n = 0;
    int blen;
    logic [AW-1:0] a;
    burst_t b;
    a = AW'(bufIdx * 4096);
    while (w < FW && (maxBursts < 0 || n < maxBursts)) begin
      blen = (FW - w < BL) ? FW - w : BL;
      b.addr = a;
      b.len  = LW'(blen - 1);
      expBurstQ.push_back(b);
      a = a + AW'(blen * 8);
      w += blen;
      n++;
    end
    if (withDone) expDoneQ.push_back(bufIdx);
  endtask

  task automatic applyStimulus(input int lvl, input int mode, input int delay, input bit pulse);
    @(negedge clk);
    level     = LVW'(lvl);
    fifoEmpty = (lvl == 0);
    reqMode   = mode;
    ackDelay  = delay;
    if (pulse) begin
      frameStart = 1'b1;
      @(negedge clk);
      frameStart = 1'b0;
    end
  endtask

  task automatic waitFrameDone(input int target, input int budget);
    int k = 0;
    while (doneCount < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (doneCount < target) checkOutput("frameTimeout", doneCount, target);
  endtask

  task automatic waitAcks(input int target, input int budget);
    int k = 0;
    while (ackCount < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (ackCount < target) checkOutput("ackTimeout", ackCount, target);
  endtask

  task automatic closeBurst();
    if (burstOpen) checkOutput("burstReads", readsSeen, beatsExp);
    burstOpen = 1'b0;
  endtask

  // Data-request pattern changes mid-cycle so negedge sampling of the combinational read enable is stable.
  always @(posedge clk) begin
    #2;
    case (reqMode)
      0:       dataReq = 1'b1;
      1:       dataReq = ~dataReq;
      default: dataReq = 1'($urandom_range(0, 1));
    endcase
  end

  // DDR command side: accept each request after ackDelay cycles, checking it against the scoreboard.
  always begin
    logic [AW-1:0] reqAddr;
    logic [LW-1:0] reqLen;
    burst_t        e;
    @(negedge clk);
    if (wrReq && !rst) begin
      reqAddr = wrAddr;
      reqLen  = wrLen;
      if (burstOpen) checkOutput("burstReads", readsSeen, beatsExp);
      for (int k = 0; k < ackDelay; k++) begin
        @(negedge clk);
        checkOutput("reqStable", {wrReq, wrAddr, wrLen}, {1'b1, reqAddr, reqLen});
      end
      if (expBurstQ.size() == 0) begin
        checkOutput("burstUnexpected", 1, 0);
      end else begin
        e = expBurstQ.pop_front();
        checkOutput("burstAddr", wrAddr, e.addr);
        checkOutput("burstLen", wrLen, e.len);
      end
      beatsExp  = int'(reqLen) + 1;
      readsSeen = 0;
      burstOpen = 1'b1;
      ackCount++;
      wrAck = 1'b1;
      @(negedge clk);
      wrAck = 1'b0;
      checkOutput("reqDrop", wrReq, 0);
    end
  end

  // Read-side monitor: read pacing, one-cycle valid latency, no reads from an empty FIFO.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("validDelay", dataValid, prevRdEn);
      if (fifoRdEn) begin
        checkOutput("rdNeedsReq", dataReq, 1);
        if (fifoEmpty) checkOutput("rdWhileEmpty", 1, 0);
        readsSeen++;
        rdTotal++;
        if (readsSeen > beatsExp) checkOutput("overRead", readsSeen, beatsExp);
      end
      prevRdEn = fifoRdEn;
    end else begin
      prevRdEn = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst && frameDone) begin
      if (expDoneQ.size() == 0) checkOutput("doneUnexpected", 1, 0);
      else checkOutput("doneBuf", doneBuf, expDoneQ.pop_front());
      doneCount++;
    end
  end

  initial begin
    bit sawReq;
    int base;

    // Reset with random inputs, then idle after release.
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      frameStart = 1'($urandom_range(0, 1));
      level      = LVW'($urandom);
      fifoEmpty  = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    checkOutput("rstWrReq", wrReq, 0);
    checkOutput("rstWrAddr", wrAddr, 0);
    checkOutput("rstWrLen", wrLen, 0);
    checkOutput("rstRdEn", fifoRdEn, 0);
    checkOutput("rstValid", dataValid, 0);
    checkOutput("rstDone", frameDone, 0);
    checkOutput("rstDoneBuf", doneBuf, 2);
    checkOutput("rstErr", frameErr, 0);
    frameStart = 1'b0;
    level      = '0;
    fifoEmpty  = 1'b1;
    reqMode    = 0;
    rst        = 1'b0;
    sawReq = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (wrReq) sawReq = 1'b1;
    end
    checkOutput("idleNoReq", sawReq, 0);

    // Nominal frame into buffer 0.
    pushFrame(nextBuf, -1, 1);
    nextBuf = (nextBuf + 1) % 3;
    rdTotal = 0;
    applyStimulus(64, 0, 0, 1);
    waitFrameDone(1, 500);
    checkOutput("nomReads", rdTotal, 40);
    checkOutput("nomErr", frameErr, 0);

    // Water-level threshold, buffer 1.
    pushFrame(nextBuf, -1, 1);
    nextBuf = (nextBuf + 1) % 3;
    base = ackCount;
    applyStimulus(10, 0, 0, 1);
    sawReq = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (wrReq) sawReq = 1'b1;
    end
    checkOutput("thrNoReq10", sawReq, 0);
    level = LVW'(16);
    @(negedge clk);
    checkOutput("thrReqAt16", wrReq, 1);
    waitAcks(base + 2, 200);
    level = LVW'(7);
    sawReq = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (wrReq) sawReq = 1'b1;
    end
    checkOutput("thrNoReq7", sawReq, 0);
    level = LVW'(8);
    @(negedge clk);
    checkOutput("thrReqAt8", wrReq, 1);
    waitFrameDone(2, 500);

    // Backpressure: toggling data requests and a 5-cycle acknowledge delay, buffer 2.
    pushFrame(nextBuf, -1, 1);
    nextBuf = (nextBuf + 1) % 3;
    applyStimulus(64, 1, 5, 1);
    waitFrameDone(3, 1000);

    // Rotation over four consecutive frames.
    for (int f = 0; f < 4; f++) begin
      pushFrame(nextBuf, -1, 0);
      expDoneQ.push_back(rotExp[f]);
      nextBuf = (nextBuf + 1) % 3;
      applyStimulus(64, 0, 0, 1);
      waitFrameDone(4 + f, 500);
    end
    checkOutput("rotErr", frameErr, 0);

    // Reset between frames returns to buffer 0.
    repeat (3) @(negedge clk);
    closeBurst();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst2DoneBuf", doneBuf, 2);
    checkOutput("rst2WrAddr", wrAddr, 0);
    checkOutput("rst2RdEn", fifoRdEn, 0);
    rst = 1'b0;
    nextBuf = 0;

    // Mid-frame restart during the second burst.
    pushFrame(0, 2, 0);
    pushFrame(0, -1, 1);
    base = ackCount;
    applyStimulus(64, 0, 0, 0);
    frameStart = 1'b1;
    @(negedge clk);
    frameStart = 1'b0;
    waitAcks(base + 2, 200);
    @(negedge clk);
    @(negedge clk);
    frameStart = 1'b1;
    @(negedge clk);
    frameStart = 1'b0;
    base = doneCount;
    waitFrameDone(base + 1, 500);
    repeat (30) @(negedge clk);
    checkOutput("restartDoneCount", doneCount, base + 1);
    checkOutput("restartErr", frameErr, 1);

    closeBurst();
    checkOutput("burstQEmpty", expBurstQ.size(), 0);
    checkOutput("doneQEmpty", expDoneQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_in_burst_ctrl.md
Name: image_in_burst_ctrl

Overview:
- Read-side scheduler for the 16-to-64-bit camera input FIFO.
- Watches the FIFO read water level and issues fixed-length write bursts of 64-bit words to the DDR write port, then paces the FIFO read enable while data is transferred.
- Generates frame-buffer addresses, rotates among BUF_NUM frame buffers, and reports completed frames to the display/read side.

Parameters:
- BURST_LEN, 16, 64-bit words per full burst (1..256).
- LEN_WIDTH, 8, width of the burst length field; it carries BURST_LEN-1.
- LVL_WIDTH, 10, FIFO read water-level width (RD_DEPTH_WIDTH+1).
- ADDR_WIDTH, 28, byte address width.
- FRAME_WORDS, 230400, 64-bit words per frame (1280x720x16bpp/64).
- BASE_ADDR, 0, byte address of buffer 0.
- BUF_STRIDE, 32'h0020_0000, byte distance between buffers.
- BUF_NUM, 3, number of frame buffers (2..4).

Ports:
- clk  in  1  FIFO read clock / DDR user clock.
- rst  in  1  asynchronous reset, active-high.
- frame_start  in  1  one-cycle pulse, start of a new input frame (already synchronised to clk).
- fifo_rd_water_level  in  LVL_WIDTH  FIFO words available.
- fifo_rd_empty  in  1  FIFO empty.
- fifo_rd_en  out  1  FIFO read enable.
- wr_req  out  1  burst request.
- wr_addr  out  ADDR_WIDTH  burst start byte address.
- wr_len  out  LEN_WIDTH  burst length minus 1.
- wr_ack  in  1  request accepted (one-cycle pulse).
- wr_data_req  in  1  DDR side pulls one word this cycle.
- wr_data_valid  out  1  rd_data from FIFO valid this cycle.
- frame_done  out  1  one-cycle pulse, frame fully written.
- done_buf  out  2  index of the last completed buffer.
- frame_err  out  1  sticky; frame_start arrived mid-frame.

Behaviour:
- Reset values:
  - wr_req=0, wr_addr=BASE_ADDR, wr_len=0.
  - fifo_rd_en=0, wr_data_valid=0.
  - frame_done=0, done_buf=BUF_NUM-1, frame_err=0.
  - Internal buffer index=0, word count=0, state IDLE.
- States and transitions:
  - IDLE: wait for frame_start. On the pulse, clear word count and set cur_addr=BASE_ADDR+buf_idx*BUF_STRIDE. Go to WAIT.
  - WAIT: compute rem=FRAME_WORDS-word_count and blen=min(BURST_LEN,rem).
    - If fifo_rd_water_level>=blen: latch wr_addr=cur_addr and wr_len=blen-1, assert wr_req, go to REQ.
  - REQ: hold wr_req, wr_addr and wr_len stable until wr_ack. On wr_ack, deassert wr_req the next cycle, load beats=blen, go to XFER.
  - XFER: fifo_rd_en=wr_data_req & (beats!=0), combinational.
    - Each read decrements beats and increments word_count.
    - wr_data_valid=fifo_rd_en delayed by one register (FIFO has no output register: 1-cycle read latency).
    - When beats reaches 0, add blen*8 to cur_addr.
    - If word_count==FRAME_WORDS go to DONE, else go to WAIT.
    - wr_data_req while beats==0 is ignored; no read is issued.
  - DONE, one cycle:
    - Pulse frame_done, done_buf=buf_idx.
    - buf_idx=(buf_idx==BUF_NUM-1)?0:buf_idx+1.
    - Go to IDLE, or directly start the next frame if a frame_start is pending.
- frame_start handling in other states:
  - WAIT: set frame_err, abandon the current frame (no frame_done, buf_idx unchanged), restart at the same buffer base.
  - REQ or XFER: latch as pending. After the burst ends, treat it as the WAIT case.
  - DONE: latch as pending; the next frame starts without passing through IDLE.
- Reads while fifo_rd_empty=1 never occur by construction. The bench asserts this.
- Widths: cur_addr wraps modulo 2^ADDR_WIDTH. word_count width is clog2(FRAME_WORDS+1).
- Reset mid-burst: all outputs return to reset values immediately; no residual fifo_rd_en. The FIFO is reset by its own reset.

Optional Feature:
- Macro IMAGE_IN_BURST_STAT_EN.
- Defined: adds output burst_cnt [15:0] and output max_lvl [LVL_WIDTH-1:0].
  - burst_cnt counts wr_ack pulses; it wraps and clears on rst.
  - max_lvl holds the peak fifo_rd_water_level seen since reset.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Test Plan (FRAME_WORDS=40, BURST_LEN=16, BUF_NUM=3, BASE_ADDR=0, BUF_STRIDE=4096):
- Reset: rst=1 with random inputs -> all outputs at reset values; wr_req=0 for 20 cycles after release with no frame_start.
- Nominal frame: frame_start, water level 64, wr_ack one cycle after wr_req, wr_data_req held 1 ->
  - bursts at addr 0/128/256 with wr_len 15/15/7;
  - fifo_rd_en high for exactly 40 cycles;
  - wr_data_valid follows one cycle later;
  - frame_done once with done_buf=0.
- Threshold: water level 10 with 16 needed -> no wr_req. Raise to 16 -> wr_req the next cycle.
  - Last burst needs 8 and proceeds at level 8.
- Backpressure: wr_data_req toggles 1/0 and wr_ack is delayed 5 cycles ->
  - wr_req, wr_addr and wr_len stay stable while waiting;
  - fifo_rd_en only when wr_data_req=1;
  - exactly 16 reads per full burst.
- Rotation: 4 consecutive frames -> done_buf 0,1,2,0; burst base addresses 0, 4096, 8192, 0.
- Mid-frame restart: frame_start during XFER of burst 2 ->
  - burst 2 completes;
  - frame_err=1;
  - next burst at the same buffer base 0;
  - no frame_done for the abandoned frame.
